// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Centralised hazard / pipeline-control unit for a 5-stage RV32 pipeline.
// It sits beside the stage modules and owns every stall, flush and forward
// select. It also keeps the cycle, instret and stall performance counters.
//
// Functions:
//   - EX operand forwarding (MEM result has priority over WB result)
//   - load-use stall detection (one-cycle freeze of PC and IF/ID, bubble in EX)
//   - taken-branch flush of IF/ID and ID/EX
//   - multi-cycle execute (MUL/DIV) stall FSM, MC_LATENCY cycles per op
//   - cycle / instret / stall counters, wrapping, with a synchronous clear
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   rs1_D, rs2_D             source registers of the instruction in ID
//   rs1_E, rs2_E, rd_E       sources / destination of the instruction in EX
//   MemRead_E                instruction in EX is a load
//   rd_M, RegWrite_M         destination / write enable of MEM
//   rd_W, RegWrite_W         destination / write enable of WB
//   mc_start_E               valid multi-cycle op in EX
//   PCSrc_E                  taken branch/jump resolved in EX
//   retire_W                 valid instruction retiring in WB
//   counter_clr              synchronous clear of all counters
//   ForwardA_E, ForwardB_E   00 regfile, 01 WB result, 10 MEM ALU result
//   PC_Write, IF_ID_Write,
//   ID_EX_Write              pipeline register enables
//   Flush_D, Flush_E         clear IF/ID, clear ID/EX
//   Bubble_M                 clear EX/MEM
//   mc_done                  final cycle of a multi-cycle op
//   cycle_cnt, instret_cnt,
//   stall_cnt                performance counters
//
// All control outputs are combinational so that a hazard detected in a cycle
// takes effect at the very next clock edge; only FSM state and the counters
// are registered.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rs1_E,
  input  logic [REG_ADDR_W-1:0] rs2_E,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic                  MemRead_E,
  input  logic [REG_ADDR_W-1:0] rd_M,
  input  logic                  RegWrite_M,
  input  logic [REG_ADDR_W-1:0] rd_W,
  input  logic                  RegWrite_W,
  input  logic                  mc_start_E,
  input  logic                  PCSrc_E,
  input  logic                  retire_W,
  input  logic                  counter_clr,
  output logic [1:0]            ForwardA_E,
  output logic [1:0]            ForwardB_E,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  Flush_D,
  output logic                  Flush_E,
  output logic                  Bubble_M,
  output logic                  mc_done,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  instret_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  // Forward select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};

  // mc_cnt value on the op's final (done) cycle
  localparam logic [7:0] MC_LAST = 8'(MC_LATENCY - 1);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_t;

  mc_state_t        r_state;
  mc_state_t        w_state_nxt;
  logic [7:0]       r_mc_cnt;
  logic [7:0]       w_mc_cnt_nxt;
  logic             w_mc_stall;
  logic             w_mc_done;
  logic             w_load_use;
  logic             w_rs1_hit;
  logic             w_rs2_hit;

  // Forward select for one EX operand; x0 is never forwarded because it is
  // hard-wired to zero regardless of what an older instruction "writes".
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] rd_mem,
    input logic                  wr_mem,
    input logic [REG_ADDR_W-1:0] rd_wb,
    input logic                  wr_wb
  );
    logic [1:0] sel;
    if (wr_mem && (rd_mem != ZERO_REG) && (rd_mem == src)) begin
      sel = FWD_MEM;
    end else if (wr_wb && (rd_wb != ZERO_REG) && (rd_wb == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Load-use: the load in EX writes a register the ID instruction reads.
  always_comb begin
    w_rs1_hit  = (rd_E == rs1_D);
    w_rs2_hit  = (rd_E == rs2_D);
    w_load_use = MemRead_E && (rd_E != ZERO_REG) && (w_rs1_hit || w_rs2_hit);
  end

  // Multi-cycle FSM next state. mc_cnt counts the EX cycles already spent;
  // the stall covers every cycle except the last one, in which the result is
  // available and the pipeline may advance. A new mc_start_E on the done
  // cycle belongs to the op that is finishing and is therefore not a new op.
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    w_mc_stall   = 1'b0;
    w_mc_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mc_start_E) begin
          w_mc_stall   = 1'b1;
          w_state_nxt  = ST_BUSY;
          w_mc_cnt_nxt = 8'd1;
        end else begin
          w_mc_cnt_nxt = 8'd0;
        end
      end
      ST_BUSY: begin
        if (r_mc_cnt < MC_LAST) begin
          w_mc_stall   = 1'b1;
          w_mc_cnt_nxt = r_mc_cnt + 8'd1;
        end else begin
          w_mc_done    = 1'b1;
          w_state_nxt  = ST_IDLE;
          w_mc_cnt_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_mc_cnt_nxt = 8'd0;
      end
    endcase
  end

  // FSM state register; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mc_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // Control outputs by priority: MC stall > taken branch > load-use.
  // While rst is high the outputs are forced to their reset values so that
  // stray inputs cannot produce a stall or flush during reset.
  always_comb begin
    ForwardA_E  = FWD_RF;
    ForwardB_E  = FWD_RF;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    Flush_D     = 1'b0;
    Flush_E     = 1'b0;
    Bubble_M    = 1'b0;
    mc_done     = 1'b0;
    if (rst) begin
      mc_done = 1'b0;
    end else begin
      ForwardA_E = fwd_sel(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
      ForwardB_E = fwd_sel(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
      mc_done    = w_mc_done;
      if (w_mc_stall) begin
        // Whole front end frozen; EX/MEM gets a bubble while EX is occupied.
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Write = 1'b0;
        Bubble_M    = 1'b1;
      end else if (PCSrc_E) begin
        // ID instruction is squashed, so any load-use it had is moot.
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (w_load_use) begin
        // Hold IF and ID one cycle, insert a bubble behind the load.
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        Flush_E     = 1'b1;
      end else begin
        Flush_D = 1'b0;
      end
    end
  end

  // Performance counters; clear wins over that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= CNT_ZERO;
      instret_cnt <= CNT_ZERO;
      stall_cnt   <= CNT_ZERO;
    end else if (counter_clr) begin
      cycle_cnt   <= CNT_ZERO;
      instret_cnt <= CNT_ZERO;
      stall_cnt   <= CNT_ZERO;
    end else begin
      cycle_cnt   <= cycle_cnt + CNT_ONE;
      instret_cnt <= retire_W ? (instret_cnt + CNT_ONE) : instret_cnt;
      stall_cnt   <= PC_Write ? stall_cnt : (stall_cnt + CNT_ONE);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two instances share all inputs: one with 64-bit counters, one with 8-bit
// counters so counter wrap is reachable. Expected values come from a
// behavioural model: the multi-cycle op is tracked as "cycles left in EX",
// counters as plain 64-bit integers (truncated for the 8-bit instance).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int W   = 5;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic         MemRead_E, RegWrite_M, RegWrite_W, mc_start_E, PCSrc_E;
  logic         retire_W, counter_clr;

  logic [1:0]   fa, fb, fa8, fb8;
  logic         pcw, ifid, idex, fd, fe, bm, done;
  logic         pcw8, ifid8, idex8, fd8, fe8, bm8, done8;
  logic [63:0]  cyc, inst, stl;
  logic [7:0]   cyc8, inst8, stl8;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(W), .MC_LATENCY(LAT), .CNT_WIDTH(64)) u_dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .MemRead_E(MemRead_E), .rd_M(rd_M), .RegWrite_M(RegWrite_M),
    .rd_W(rd_W), .RegWrite_W(RegWrite_W), .mc_start_E(mc_start_E),
    .PCSrc_E(PCSrc_E), .retire_W(retire_W), .counter_clr(counter_clr),
    .ForwardA_E(fa), .ForwardB_E(fb), .PC_Write(pcw), .IF_ID_Write(ifid),
    .ID_EX_Write(idex), .Flush_D(fd), .Flush_E(fe), .Bubble_M(bm),
    .mc_done(done), .cycle_cnt(cyc), .instret_cnt(inst), .stall_cnt(stl)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(W), .MC_LATENCY(LAT), .CNT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .MemRead_E(MemRead_E), .rd_M(rd_M), .RegWrite_M(RegWrite_M),
    .rd_W(rd_W), .RegWrite_W(RegWrite_W), .mc_start_E(mc_start_E),
    .PCSrc_E(PCSrc_E), .retire_W(retire_W), .counter_clr(counter_clr),
    .ForwardA_E(fa8), .ForwardB_E(fb8), .PC_Write(pcw8), .IF_ID_Write(ifid8),
    .ID_EX_Write(idex8), .Flush_D(fd8), .Flush_E(fe8), .Bubble_M(bm8),
    .mc_done(done8), .cycle_cnt(cyc8), .instret_cnt(inst8), .stall_cnt(stl8)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int          m_left;          // EX cycles left in current MC op, 0 = none
  logic [63:0] m_cyc, m_inst, m_stl;
  // model expectations for the current cycle
  logic [1:0]  e_fa, e_fb;
  logic        e_pcw, e_ifid, e_idex, e_fd, e_fe, e_bm, e_done;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [W-1:0] src);
    if (RegWrite_M && rd_M != 0 && rd_M == src) return 2'b10;
    if (RegWrite_W && rd_W != 0 && rd_W == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_left = 0; m_cyc = 64'd0; m_inst = 64'd0; m_stl = 64'd0;
  endtask

  task automatic model_outputs();
    logic mc_stall, lu;
    e_fa = 2'b00; e_fb = 2'b00;
    e_pcw = 1'b1; e_ifid = 1'b1; e_idex = 1'b1;
    e_fd = 1'b0; e_fe = 1'b0; e_bm = 1'b0; e_done = 1'b0;
    if (!rst) begin
      e_fa = m_fwd(rs1_E);
      e_fb = m_fwd(rs2_E);
      mc_stall = (m_left == 0 && mc_start_E) || (m_left > 1);
      e_done   = (m_left == 1);
      lu = MemRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
      if (mc_stall) begin
        e_pcw = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_bm = 1'b1;
      end else if (PCSrc_E) begin
        e_fd = 1'b1; e_fe = 1'b1;
      end else if (lu) begin
        e_pcw = 1'b0; e_ifid = 1'b0; e_fe = 1'b1;
      end
    end
  endtask

  // One clock cycle: check outputs for the current inputs, then advance the
  // model across the rising edge; returns at the next falling edge.
  task automatic run_cycle();
    #1;
    if (rst) model_reset();
    model_outputs();
    check_val("ForwardA_E", fa, e_fa);
    check_val("ForwardB_E", fb, e_fb);
    check_val("PC_Write", pcw, e_pcw);
    check_val("IF_ID_Write", ifid, e_ifid);
    check_val("ID_EX_Write", idex, e_idex);
    check_val("Flush_D", fd, e_fd);
    check_val("Flush_E", fe, e_fe);
    check_val("Bubble_M", bm, e_bm);
    check_val("mc_done", done, e_done);
    check_val("cycle_cnt", cyc, m_cyc);
    check_val("instret_cnt", inst, m_inst);
    check_val("stall_cnt", stl, m_stl);
    check_val("w8_PC_Write", pcw8, e_pcw);
    check_val("w8_Bubble_M", bm8, e_bm);
    check_val("w8_mc_done", done8, e_done);
    check_val("w8_cycle_cnt", cyc8, m_cyc[7:0]);
    check_val("w8_instret_cnt", inst8, m_inst[7:0]);
    check_val("w8_stall_cnt", stl8, m_stl[7:0]);
    @(posedge clk);
    if (!rst) begin
      if (m_left == 0) begin
        if (mc_start_E) m_left = LAT - 1;
      end else begin
        m_left = m_left - 1;
      end
      if (counter_clr) begin
        m_cyc = 64'd0; m_inst = 64'd0; m_stl = 64'd0;
      end else begin
        m_cyc  = m_cyc + 64'd1;
        m_inst = m_inst + (retire_W ? 64'd1 : 64'd0);
        m_stl  = m_stl + (e_pcw ? 64'd0 : 64'd1);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0;
    rd_M = '0; rd_W = '0; MemRead_E = 1'b0; RegWrite_M = 1'b0;
    RegWrite_W = 1'b0; mc_start_E = 1'b0; PCSrc_E = 1'b0;
    retire_W = 1'b0; counter_clr = 1'b0;
  endtask

  initial begin
    logic [63:0] stl_before;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    run_cycle();
    check_val("rst_PC_Write", pcw, 64'd1);
    check_val("rst_cycle_cnt", cyc, 64'd0);
    rst = 1'b0;

    // idle: ten cycles, no stalls
    repeat (10) run_cycle();
    #1;
    check_val("idle_cycle10", cyc, 64'd10);
    check_val("idle_stall0", stl, 64'd0);

    // forwarding: MEM beats WB, then WB when MEM targets x0
    RegWrite_M = 1'b1; rd_M = 5'd5; RegWrite_W = 1'b1; rd_W = 5'd5;
    rs1_E = 5'd5; rs2_E = 5'd0;
    #1;
    check_val("fwd_mem_prio", fa, 64'd2);
    check_val("fwd_x0", fb, 64'd0);
    run_cycle();
    rd_M = 5'd0;
    #1;
    check_val("fwd_wb", fa, 64'd1);
    run_cycle();
    idle_inputs();

    // load-use: one-cycle stall
    stl_before = stl;
    MemRead_E = 1'b1; rd_E = 5'd3; rs2_D = 5'd3;
    #1;
    check_val("lu_pcw", pcw, 64'd0);
    check_val("lu_flush_e", fe, 64'd1);
    run_cycle();
    idle_inputs();
    #1;
    check_val("lu_stall_inc", stl, stl_before + 64'd1);

    // multi-cycle op: mc_start_E held LAT cycles, branch in cycle 2 ignored
    stl_before = stl;
    mc_start_E = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      PCSrc_E = (c == 2);
      #1;
      check_val("mc_done_cycle", done, (c == LAT) ? 64'd1 : 64'd0);
      check_val("mc_no_flush", fd, 64'd0);
      run_cycle();
    end
    idle_inputs();
    #1;
    check_val("mc_stall_inc", stl, stl_before + 64'd3);

    // branch together with load-use: flush wins, no stall
    stl_before = stl;
    PCSrc_E = 1'b1; MemRead_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
    #1;
    check_val("br_lu_pcw", pcw, 64'd1);
    check_val("br_lu_fd", fd, 64'd1);
    run_cycle();
    idle_inputs();
    #1;
    check_val("br_lu_stall_same", stl, stl_before);

    // reset in cycle 2 of an MC op
    mc_start_E = 1'b1;
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0; mc_start_E = 1'b0;
    #1;
    check_val("rst_mid_pcw", pcw, 64'd1);
    check_val("rst_mid_done", done, 64'd0);
    check_val("rst_mid_cnt", cyc, 64'd0);
    run_cycle();
    run_cycle();

    // counter clear then 8-bit wrap
    retire_W = 1'b1;
    repeat (5) run_cycle();
    counter_clr = 1'b1;
    run_cycle();
    counter_clr = 1'b0; retire_W = 1'b0;
    #1;
    check_val("clr_cycle", cyc, 64'd0);
    repeat (255) run_cycle();
    #1;
    check_val("w8_pre_wrap", cyc8, 64'd255);
    run_cycle();
    #1;
    check_val("w8_wrap", cyc8, 64'd0);
    check_val("w64_no_wrap", cyc, 64'd256);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs1_D = W'($urandom_range(0, 3)); rs2_D = W'($urandom_range(0, 3));
      rs1_E = W'($urandom_range(0, 3)); rs2_E = W'($urandom_range(0, 3));
      rd_E  = W'($urandom_range(0, 3)); rd_M  = W'($urandom_range(0, 3));
      rd_W  = W'($urandom_range(0, 3));
      MemRead_E   = ($urandom_range(0, 2) == 0);
      RegWrite_M  = $urandom_range(0, 1) == 1;
      RegWrite_W  = $urandom_range(0, 1) == 1;
      mc_start_E  = ($urandom_range(0, 7) == 0);
      PCSrc_E     = ($urandom_range(0, 4) == 0);
      retire_W    = $urandom_range(0, 1) == 1;
      counter_clr = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Centralised hazard and pipeline-control unit for the 5-stage RV32 pipeline. It is the successor to the forwarding-only hazard unit. It adds:
- load-use stall detection
- taken-branch flush
- a multi-cycle execute-unit (MUL/DIV) stall FSM with parametrised latency
- cycle, instret and stall performance counters

It sits beside the stage modules in the CPU top level and drives every stall, flush and forward select.

Parameters:
REG_ADDR_W, 5, register index width
MC_LATENCY, 4, total cycles a multi-cycle op occupies EX (legal range 2..255)
CNT_WIDTH, 64, width of each performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
rs1_D  input  REG_ADDR_W  rs1 of instruction in ID
rs2_D  input  REG_ADDR_W  rs2 of instruction in ID
rs1_E  input  REG_ADDR_W  rs1 of instruction in EX
rs2_E  input  REG_ADDR_W  rs2 of instruction in EX
rd_E  input  REG_ADDR_W  destination in EX
MemRead_E  input  1  instruction in EX is a load
rd_M  input  REG_ADDR_W  destination in MEM
RegWrite_M  input  1  MEM writes the register file
rd_W  input  REG_ADDR_W  destination in WB
RegWrite_W  input  1  WB writes the register file
mc_start_E  input  1  valid multi-cycle op in EX
PCSrc_E  input  1  taken branch/jump resolved in EX
retire_W  input  1  valid instruction retiring in WB
counter_clr  input  1  synchronous clear of all counters
ForwardA_E  output  2  00 regfile, 01 WB result, 10 MEM ALU result
ForwardB_E  output  2  same encoding for rs2
PC_Write  output  1  PC register enable
IF_ID_Write  output  1  IF/ID register enable
ID_EX_Write  output  1  ID/EX register enable
Flush_D  output  1  clear IF/ID to NOP
Flush_E  output  1  clear ID/EX to bubble
Bubble_M  output  1  clear EX/MEM to bubble
mc_done  output  1  final cycle of a multi-cycle op
cycle_cnt  output  CNT_WIDTH  cycles since reset/clear
instret_cnt  output  CNT_WIDTH  retired instructions
stall_cnt  output  CNT_WIDTH  cycles with PC_Write=0

Behaviour:
- Reset (asynchronous, active-high) while rst=1:
  - FSM=IDLE, mc_cnt=0, all counters 0.
  - PC_Write=IF_ID_Write=ID_EX_Write=1.
  - Flush_D=Flush_E=Bubble_M=mc_done=0; ForwardA_E=ForwardB_E=00.
- Reset mid-op: a reset during BUSY aborts the op. There is no mc_done and no residual stall after release.
- Forwarding (combinational), per operand X in {rs1_E, rs2_E}:
  - 10 if RegWrite_M && rd_M!=0 && rd_M==X.
  - else 01 if RegWrite_W && rd_W!=0 && rd_W==X.
  - else 00. MEM has priority over WB.
- Load-use condition: MemRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
- Multi-cycle FSM, states IDLE and BUSY, mc_cnt 8-bit:
  - IDLE with mc_start_E=1: stall asserted this cycle; next state BUSY with mc_cnt<=1.
  - BUSY, mc_cnt<MC_LATENCY-1: stall asserted; mc_cnt++.
  - BUSY, mc_cnt==MC_LATENCY-1: stall released; mc_done=1; next state IDLE. mc_start_E is ignored in this cycle because it belongs to the same op.
  - Result: stall lasts exactly MC_LATENCY-1 cycles and mc_done lasts 1 cycle.
- Control priority (highest first):
  - MC stall: PC_Write=IF_ID_Write=ID_EX_Write=0, Bubble_M=1, Flush_D=Flush_E=0. PCSrc_E and load-use are ignored.
  - PCSrc_E: Flush_D=1, Flush_E=1, all enables=1. Load-use is suppressed because the ID instruction is squashed.
  - Load-use: PC_Write=IF_ID_Write=0, ID_EX_Write=1, Flush_E=1, for one cycle (the load then moves to MEM).
  - Otherwise: all enables=1, flushes/bubble=0.
- Counters:
  - cycle_cnt increments every cycle.
  - instret_cnt increments when retire_W=1.
  - stall_cnt increments when PC_Write=0.
  - All counters wrap modulo 2^CNT_WIDTH.
  - counter_clr=1 loads 0 at the next edge and overrides that cycle's increment.

Test Plan:
- Reset, then release with all inputs 0 -> all enables 1, flushes 0; after 10 cycles cycle_cnt=10, stall_cnt=0.
- RegWrite_M=1, rd_M=5, RegWrite_W=1, rd_W=5, rs1_E=5, rs2_E=0 -> ForwardA_E=10, ForwardB_E=00. Repeat with rd_M=0 -> ForwardA_E=01.
- MemRead_E=1, rd_E=3, rs2_D=3 -> for one cycle PC_Write=0, IF_ID_Write=0, Flush_E=1; stall_cnt +1.
- MC_LATENCY=4, mc_start_E held 4 cycles -> stall for 3 cycles with Bubble_M=1; mc_done=1 on cycle 4; stall_cnt +3. Also assert PCSrc_E=1 in cycle 2 -> no flush.
- PCSrc_E=1 together with the load-use condition -> Flush_D=Flush_E=1, PC_Write=1, stall_cnt unchanged.
- rst=1 in cycle 2 of an MC op, released 1 cycle later -> enables=1 immediately, no mc_done, counters 0. Separately, preload cycle_cnt near 2^CNT_WIDTH-1 (CNT_WIDTH=8) -> wraps to 0; counter_clr -> 0 next cycle.
